vx_wb_arbiter: RTL and testbench
================================

VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 4, number of execute-unit commit sources.
REQ-002 SHALL have parameter NUM_THREADS, default 4, lanes per beat.
REQ-003 SHALL have parameter XLEN, default 32, lane data width.
REQ-004 SHALL have parameter NR_BITS, default 6, register index width.
REQ-005 SHALL have parameter WIS_W, default 2, warp-in-slot index width, minimum 1.
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports src_valid / src_ready  input / output  NUM_SRCS each  per-source beat handshake.
REQ-009 SHALL have ports src_wis, src_tmask, src_rd, src_data, src_sop, src_eop  input  NUM_SRCS x (WIS_W, NUM_THREADS, NR_BITS, NUM_THREADS*XLEN, 1, 1)  per-source beat payload.
REQ-010 SHALL have ports wb_valid, wb_wis, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop  output  1, WIS_W, NUM_THREADS, NR_BITS, NUM_THREADS*XLEN, 1, 1  writeback stream; valid-only, no ready, feeds operand-stage GPR and operand cache.

Function
REQ-011 SHALL accept at most one source beat per cycle; a beat transfers when src_valid[g] && src_ready[g].
REQ-012 SHALL register the accepted beat and present it on wb_* exactly 1 cycle later with wb_valid=1; with no transfer, wb_valid=0 next cycle and wb_* payload holds its last value.
REQ-013 SHALL drive src_ready high only for the granted source, and only when that source is valid; all other src_ready=0.
REQ-014 SHALL use a two-state FSM: IDLE (arbitrate) and LOCKED (hold grant on lock_src).
REQ-015 In IDLE SHALL grant round-robin: first valid source at or after rr_ptr, wrapping NUM_SRCS-1 -> 0.
REQ-016 In IDLE, a granted beat with sop=1, eop=0 SHALL go to LOCKED with lock_src=grant; a beat with eop=1 SHALL stay IDLE.
REQ-017 In LOCKED SHALL grant only lock_src; if lock_src is not valid, no transfer occurs (output bubble) and other sources stall.
REQ-018 In LOCKED, an accepted eop=1 beat SHALL return to IDLE the next cycle; a new source may be granted that next cycle (no bubble).
REQ-019 On every accepted eop=1 beat SHALL set rr_ptr = (grant+1) mod NUM_SRCS; non-eop beats SHALL leave rr_ptr unchanged.
REQ-020 SHALL never interleave beats of different packets on wb_*; sop..eop of one packet appear contiguous in accept order.
REQ-021 SHALL pass the payload through unmodified, rd==0 included.
REQ-022 Protocol violations (sop=1 from lock_src while LOCKED; eop without prior sop) SHALL raise a simulation-only assertion, with no defined recovery.

Reset
REQ-023 SHALL on reset set state=IDLE, rr_ptr=0, wb_valid=0 and all src_ready=0 during reset; wb payload registers need not reset.
REQ-024 SHALL abandon any lock on reset mid-packet; the first post-reset grant follows REQ-015 from rr_ptr=0.

Configuration
REQ-025 With WB_ARB_PERF_EN defined, SHALL add output perf_stall_cycles (32 bits, reset 0), incremented each cycle where any src_valid=1 and that source is not granted; wraps at 2^32-1 -> 0.
REQ-026 Without WB_ARB_PERF_EN, the perf_stall_cycles port and counter SHALL be absent.

Structure
REQ-027 The writeback beat struct (wis, tmask, rd, data, sop, eop) SHALL be a typedef in VX_gpu_pkg, shared with the operand stage.
REQ-028 Round-robin selection SHALL be a sub-module VX_wb_rr_picker (inputs: valid vector, rr_ptr; outputs: one-hot grant, grant index, any_valid).

Verification
REQ-029 Single beats: src0 and src2 valid, sop=eop=1, rr_ptr=0 -> src0 on wb at t+1, src2 at t+2, rr_ptr=3 afterwards.
REQ-030 Packet lock: src1 sends 3 beats (sop, mid, eop) while src0 is continuously valid -> wb shows src1 x3 contiguously, then src0; src0 src_ready=0 throughout.
REQ-031 Locked bubble: src1 deasserts valid after its sop beat for 2 cycles -> wb_valid=0 for 2 cycles, src3 (valid) not granted until after src1's eop.
REQ-032 Back-to-back: src2's eop is accepted in cycle t while src3 is valid -> src3 accepted in t+1, wb_valid high in t+1 and t+2.
REQ-033 Reset mid-packet: reset asserted in LOCKED on src1 -> next cycle wb_valid=0, state IDLE; after release with src0 and src1 valid, src0 granted first.
REQ-034 PERF: with WB_ARB_PERF_EN, 4 sources valid for 10 cycles of single beats -> perf_stall_cycles increases by 30.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - shared writeback beat type, arbiter FSM encodings and width helper
package vx_gpu_pkg;

    localparam int WB_NUM_THREADS = 4;
    localparam int WB_XLEN        = 32;
    localparam int WB_NR_BITS     = 6;
    localparam int WB_WIS_W       = 2;

    // Writeback beat as seen by the operand stage (GPR write port and operand cache).
    typedef struct packed {
        logic [WB_WIS_W-1:0]               wis;
        logic [WB_NUM_THREADS-1:0]         tmask;
        logic [WB_NR_BITS-1:0]             rd;
        logic [WB_NUM_THREADS*WB_XLEN-1:0] data;
        logic                              sop;
        logic                              eop;
    } wb_beat_t;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_wb_rr_picker.sv
// rtl/vx_wb_rr_picker.sv - round-robin picker: first valid source at or after rr_ptr, wrapping
module vx_wb_rr_picker
    import vx_gpu_pkg::*;
#(
    parameter int NUM_SRCS = 4,
    parameter int IDX_W    = clog2_min1(NUM_SRCS)
) (
    input  logic [NUM_SRCS-1:0] valid,
    input  logic [IDX_W-1:0]    rr_ptr,
    output logic [NUM_SRCS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                any_valid
);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Walk offsets from farthest to nearest so the nearest valid source wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = |valid;
        idx       = 0;
        sel       = '0;
        for (int off = NUM_SRCS - 1; off >= 0; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_SRCS) idx = idx - NUM_SRCS;
            sel = IDX_W'(idx);
            if (valid[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/vx_wb_arbiter.sv
// rtl/vx_wb_arbiter.sv - packet-locking round-robin writeback arbiter; WB_ARB_PERF_EN adds perf_stall_cycles
module vx_wb_arbiter
    import vx_gpu_pkg::*;
#(
    parameter int NUM_SRCS    = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_W       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRCS-1:0]         src_valid,
    output logic [NUM_SRCS-1:0]         src_ready,
    input  logic [WIS_W-1:0]            src_wis   [NUM_SRCS],
    input  logic [NUM_THREADS-1:0]      src_tmask [NUM_SRCS],
    input  logic [NR_BITS-1:0]          src_rd    [NUM_SRCS],
    input  logic [NUM_THREADS*XLEN-1:0] src_data  [NUM_SRCS],
    input  logic                        src_sop   [NUM_SRCS],
    input  logic                        src_eop   [NUM_SRCS],
    output logic                        wb_valid,
    output logic [WIS_W-1:0]            wb_wis,
    output logic [NUM_THREADS-1:0]      wb_tmask,
    output logic [NR_BITS-1:0]          wb_rd,
    output logic [NUM_THREADS*XLEN-1:0] wb_data,
    output logic                        wb_sop,
    output logic                        wb_eop
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cycles
`endif
);

    localparam int IDX_W = clog2_min1(NUM_SRCS);

    logic [0:0]          state;
    logic [IDX_W-1:0]    lock_src;
    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_SRCS-1:0] lock_mask;
    logic [NUM_SRCS-1:0] cand_valid;
    logic [NUM_SRCS-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_valid;
    logic                fire;
    logic                sel_sop;
    logic                sel_eop;
    logic [IDX_W-1:0]    next_ptr;

    // While locked only the owning source may compete, so other sources stall.
    always_comb begin
        lock_mask           = '0;
        lock_mask[lock_src] = 1'b1;
        cand_valid          = (state == ARB_LOCKED) ? (src_valid & lock_mask) : src_valid;
    end

    vx_wb_rr_picker #(
        .NUM_SRCS (NUM_SRCS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .valid     (cand_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign src_ready = reset ? '0 : grant;
    assign fire      = any_valid & ~reset;
    assign sel_sop   = src_sop[grant_idx];
    assign sel_eop   = src_eop[grant_idx];
    assign next_ptr  = (grant_idx == IDX_W'(NUM_SRCS - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            lock_src <= '0;
            rr_ptr   <= '0;
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= fire;
            if (fire) begin
                if (sel_eop) rr_ptr <= next_ptr;
                case (state)
                    ARB_IDLE: begin
                        if (sel_sop && !sel_eop) begin
                            state    <= ARB_LOCKED;
                            lock_src <= grant_idx;
                        end
                    end
                    default: begin
                        if (sel_eop) state <= ARB_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            wb_wis   <= src_wis[grant_idx];
            wb_tmask <= src_tmask[grant_idx];
            wb_rd    <= src_rd[grant_idx];
            wb_data  <= src_data[grant_idx];
            wb_sop   <= sel_sop;
            wb_eop   <= sel_eop;
        end
    end

`ifdef WB_ARB_PERF_EN
    // Counts source-cycles lost to arbitration, not just cycles with some stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + 32'($countones(src_valid & ~grant));
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && fire) begin
            if (state == ARB_LOCKED) begin
                assert (!sel_sop) else $error("vx_wb_arbiter: sop from lock_src while locked");
            end else begin
                assert (sel_sop || !sel_eop) else $error("vx_wb_arbiter: eop without prior sop");
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// tb/tb_vx_wb_arbiter.sv - scoreboard bench for vx_wb_arbiter (perf checks when WB_ARB_PERF_EN is defined)
module tb_vx_wb_arbiter;

    localparam int NS = 4;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] src_valid;
    logic [NS-1:0] src_ready;
    logic [1:0]    src_wis   [NS];
    logic [3:0]    src_tmask [NS];
    logic [5:0]    src_rd    [NS];
    logic [DW-1:0] src_data  [NS];
    logic          src_sop   [NS];
    logic          src_eop   [NS];
    logic          wb_valid;
    logic [1:0]    wb_wis;
    logic [3:0]    wb_tmask;
    logic [5:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          wb_sop;
    logic          wb_eop;
`ifdef WB_ARB_PERF_EN
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_exp;
    logic [31:0]   perf_base;
`endif

    vx_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_wis   (src_wis),
        .src_tmask (src_tmask),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .wb_valid  (wb_valid),
        .wb_wis    (wb_wis),
        .wb_tmask  (wb_tmask),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_sop    (wb_sop),
        .wb_eop    (wb_eop)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    wis;
        logic [3:0]    tmask;
        logic [5:0]    rd;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t   exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      pkt_len  [NS];
    int      beat_idx [NS];
    int      seq      [NS];
    bit      rand_mode = 0;
    bit      m_locked;
    int      m_lock;
    int      m_ptr;
    logic [NS-1:0] obs_ready;
    logic          obs_wb_valid;

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_payload();
        for (int s = 0; s < NS; s++) begin
            src_wis[s]   = 2'(s);
            src_tmask[s] = 4'(beat_idx[s] + s + 1);
            src_rd[s]    = 6'(s * 3 + beat_idx[s] * 7 + seq[s] * 11);
            src_data[s]  = {4{8'(s), 8'(beat_idx[s]), 16'(seq[s])}};
            src_sop[s]   = (beat_idx[s] == 0);
            src_eop[s]   = (beat_idx[s] == pkt_len[s] - 1);
        end
    endtask

    // One clock: predict grant, check ready, advance, check writeback one cycle later.
    task automatic step();
        int            g;
        logic [NS-1:0] exp_ready;
        beat_t         b;
        set_payload();
        #1;
        g = -1;
        if (!reset) begin
            if (m_locked) begin
                if (src_valid[m_lock]) g = m_lock;
            end else begin
                for (int k = 0; k < NS; k++) begin
                    if (src_valid[(m_ptr + k) % NS]) begin
                        g = (m_ptr + k) % NS;
                        break;
                    end
                end
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = src_ready;
        check_val("src_ready", DW'(src_ready), DW'(exp_ready));
        if (g >= 0) begin
            b.wis = src_wis[g]; b.tmask = src_tmask[g]; b.rd = src_rd[g];
            b.data = src_data[g]; b.sop = src_sop[g]; b.eop = src_eop[g];
            exp_q.push_back(b);
        end
`ifdef WB_ARB_PERF_EN
        if (reset) perf_exp = '0;
        else perf_exp = perf_exp + 32'($countones(src_valid & ~exp_ready));
`endif
        @(posedge clk);
        #1;
        if (reset) begin
            m_locked = 0; m_ptr = 0; m_lock = 0;
            for (int s = 0; s < NS; s++) beat_idx[s] = 0;
        end else if (g >= 0) begin
            if (!m_locked && src_sop[g] && !src_eop[g]) begin
                m_locked = 1; m_lock = g;
            end else if (m_locked && src_eop[g]) begin
                m_locked = 0;
            end
            seq[g]++;
            if (src_eop[g]) begin
                m_ptr = (g + 1) % NS;
                beat_idx[g] = 0;
                if (rand_mode) pkt_len[g] = $urandom_range(1, 3);
            end else begin
                beat_idx[g]++;
            end
        end
        obs_wb_valid = wb_valid;
        if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check_val("wb_valid", DW'(wb_valid), DW'(1'b1));
            check_val("wb_wis", DW'(wb_wis), DW'(b.wis));
            check_val("wb_tmask", DW'(wb_tmask), DW'(b.tmask));
            check_val("wb_rd", DW'(wb_rd), DW'(b.rd));
            check_val("wb_data", wb_data, b.data);
            check_val("wb_sop_eop", DW'({wb_sop, wb_eop}), DW'({b.sop, b.eop}));
        end else begin
            check_val("wb_valid_idle", DW'(wb_valid), DW'(1'b0));
        end
`ifdef WB_ARB_PERF_EN
        check_val("perf_stall_cycles", DW'(perf_stall_cycles), DW'(perf_exp));
`endif
    endtask

    task automatic drive(input logic [NS-1:0] v);
        src_valid = v;
        step();
    endtask

    initial begin
        reset = 1'b1;
        src_valid = '0;
        m_locked = 0; m_lock = 0; m_ptr = 0;
`ifdef WB_ARB_PERF_EN
        perf_exp = '0;
`endif
        for (int s = 0; s < NS; s++) begin
            pkt_len[s] = 1; beat_idx[s] = 0; seq[s] = 0;
        end
        @(posedge clk);
        #1;
        drive(4'b0000);
        drive(4'b0011);
        check_val("reset_ready", DW'(obs_ready), DW'(4'b0000));
        check_val("reset_wb_valid", DW'(obs_wb_valid), DW'(1'b0));
        reset = 1'b0;

        // Single beats from src0 and src2, then src3 wins from rr_ptr=3.
        drive(4'b0101); check_val("single_src0", DW'(obs_ready), DW'(4'b0001));
        drive(4'b0100); check_val("single_src2", DW'(obs_ready), DW'(4'b0100));
        drive(4'b1001); check_val("rr_ptr_after_src2", DW'(obs_ready), DW'(4'b1000));

        // src1 packet of 3 beats holds off a continuously valid src0.
        pkt_len[1] = 3;
        drive(4'b0010); check_val("lock_sop", DW'(obs_ready), DW'(4'b0010));
        drive(4'b0011); check_val("lock_mid_src0_stall", DW'(obs_ready), DW'(4'b0010));
        drive(4'b0011); check_val("lock_eop_src0_stall", DW'(obs_ready), DW'(4'b0010));
        drive(4'b0011); check_val("after_lock_src0", DW'(obs_ready), DW'(4'b0001));

        // Locked bubble while src3 waits.
        drive(4'b1010); check_val("bubble_sop", DW'(obs_ready), DW'(4'b0010));
        for (int i = 0; i < 2; i++) begin
            drive(4'b1000);
            check_val("bubble_ready", DW'(obs_ready), DW'(4'b0000));
            check_val("bubble_wb_valid", DW'(obs_wb_valid), DW'(1'b0));
        end
        drive(4'b1010); check_val("bubble_mid", DW'(obs_ready), DW'(4'b0010));
        drive(4'b1010); check_val("bubble_eop", DW'(obs_ready), DW'(4'b0010));
        drive(4'b1000); check_val("bubble_then_src3", DW'(obs_ready), DW'(4'b1000));

        // Back-to-back: src2 eop then src3 with no gap.
        pkt_len[2] = 2;
        drive(4'b0100);
        drive(4'b1100); check_val("b2b_src2_eop", DW'(obs_ready), DW'(4'b0100));
        check_val("b2b_wb_t", DW'(obs_wb_valid), DW'(1'b1));
        drive(4'b1000); check_val("b2b_src3", DW'(obs_ready), DW'(4'b1000));
        check_val("b2b_wb_t1", DW'(obs_wb_valid), DW'(1'b1));

        // Reset mid-packet abandons the lock.
        pkt_len[1] = 3;
        drive(4'b0010);
        reset = 1'b1;
        drive(4'b0011);
        check_val("midpkt_reset_wb_valid", DW'(obs_wb_valid), DW'(1'b0));
        reset = 1'b0;
        drive(4'b0011); check_val("post_reset_src0", DW'(obs_ready), DW'(4'b0001));
        drive(4'b0010);
        drive(4'b0010);
        drive(4'b0010);

`ifdef WB_ARB_PERF_EN
        for (int s = 0; s < NS; s++) pkt_len[s] = 1;
        perf_base = perf_stall_cycles;
        for (int i = 0; i < 10; i++) drive(4'b1111);
        check_val("perf_delta_30", DW'(perf_stall_cycles - perf_base), DW'(32'd30));
`endif

        rand_mode = 1;
        for (int i = 0; i < 300; i++) drive(4'($urandom_range(0, 15)));
        drive(4'b0000);
        drive(4'b0000);
        check_val("queue_drained", DW'(exp_q.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
